// File: rtl/systolic_mac_array.sv
// Outer-product MAC array: accumulates a[i]*b[j] over `num` beats, then drains one result row per cycle.
// Optional SIGNED_MUL_EN: two's-complement operands with sign-extended products (default: unsigned).
module systolic_mac_array #(
   parameter int MULER_WIDTH  = 8,
   parameter int NUM_WIDTH    = 16,
   parameter int OUTPUT_WIDTH = 32,
   parameter int MULER_DELAY  = 1,
   parameter int ROW_SIZE     = 4,
   parameter int COLUMN_SIZE  = 4
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         num_valid,
   input  logic [NUM_WIDTH-1:0]                         num,
   input  logic [ROW_SIZE-1:0][MULER_WIDTH-1:0]         data_a,
   input  logic [COLUMN_SIZE-1:0][MULER_WIDTH-1:0]      data_b,
   output logic [COLUMN_SIZE-1:0][OUTPUT_WIDTH-1:0]     result_r,
   output logic                                         result_valid,
   output logic [((ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1)-1:0] result_row,
   output logic                                         busy
);
   localparam int RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int PW = 2 * MULER_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;
   typedef logic [ROW_SIZE-1:0][COLUMN_SIZE-1:0][PW-1:0]           prod_t;
   typedef logic [ROW_SIZE-1:0][COLUMN_SIZE-1:0][OUTPUT_WIDTH-1:0] acc_t;

   state_t                                   state_q, state_d;
   logic [NUM_WIDTH-1:0]                     cnt_q, cnt_d;
   logic [RW:0]                              row_cnt_q, row_cnt_d;
   prod_t [MULER_DELAY-1:0]                  pipe_q, pipe_d;
   logic [MULER_DELAY-1:0]                   pvld_q, pvld_d;
   acc_t                                     acc_q, acc_d;
   logic [COLUMN_SIZE-1:0][OUTPUT_WIDTH-1:0] result_r_q, result_r_d;
   logic                                     result_valid_q, result_valid_d;
   logic [RW-1:0]                            result_row_q, result_row_d;
   logic                                     busy_q, busy_d;
   prod_t                                    prod;

   // Extend operands to full product width; the low PW bits of the product are then correct either way.
   function automatic logic [PW-1:0] ext_op(input logic [MULER_WIDTH-1:0] x);
`ifdef SIGNED_MUL_EN
      return {{MULER_WIDTH{x[MULER_WIDTH-1]}}, x};
`else
      return {{MULER_WIDTH{1'b0}}, x};
`endif
   endfunction

   function automatic logic [OUTPUT_WIDTH-1:0] widen(input logic [PW-1:0] p);
`ifdef SIGNED_MUL_EN
      return OUTPUT_WIDTH'($signed(p));
`else
      return OUTPUT_WIDTH'(p);
`endif
   endfunction

   always_comb begin
      prod = '0;
      for (int i = 0; i < ROW_SIZE; i++)
         for (int j = 0; j < COLUMN_SIZE; j++)
            prod[i][j] = ext_op(data_a[i]) * ext_op(data_b[j]);
   end

   always_comb begin
      pipe_d    = pipe_q;
      pvld_d    = pvld_q;
      pipe_d[0] = prod;
      pvld_d[0] = (state_q == ACCUM);
      for (int k = 1; k < MULER_DELAY; k++) begin
         pipe_d[k] = pipe_q[k-1];
         pvld_d[k] = pvld_q[k-1];
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      row_cnt_d      = row_cnt_q;
      acc_d          = acc_q;
      result_r_d     = result_r_q;
      result_valid_d = 1'b0;
      result_row_d   = result_row_q;

      if (pvld_q[MULER_DELAY-1]) begin
         for (int i = 0; i < ROW_SIZE; i++)
            for (int j = 0; j < COLUMN_SIZE; j++)
               acc_d[i][j] = acc_q[i][j] + widen(pipe_q[MULER_DELAY-1][i][j]);
      end

      case (state_q)
         IDLE: begin
            if (num_valid) begin
               cnt_d     = num;
               acc_d     = '0;
               row_cnt_d = '0;
               state_d   = (num == '0) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            cnt_d = cnt_q - NUM_WIDTH'(1);
            if (cnt_q == NUM_WIDTH'(1)) begin
               // Counter is reused to hold the products still in flight.
               cnt_d   = NUM_WIDTH'(MULER_DELAY - 1);
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) state_d = DRAIN;
            else             cnt_d   = cnt_q - NUM_WIDTH'(1);
         end
         DRAIN: begin
            if (row_cnt_q == (RW+1)'(ROW_SIZE)) begin
               state_d = IDLE;
            end else begin
               result_r_d     = acc_q[row_cnt_q[RW-1:0]];
               result_valid_d = 1'b1;
               result_row_d   = row_cnt_q[RW-1:0];
               row_cnt_d      = row_cnt_q + (RW+1)'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         row_cnt_q      <= '0;
         pipe_q         <= '0;
         pvld_q         <= '0;
         acc_q          <= '0;
         result_r_q     <= '0;
         result_valid_q <= 1'b0;
         result_row_q   <= '0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         row_cnt_q      <= row_cnt_d;
         pipe_q         <= pipe_d;
         pvld_q         <= pvld_d;
         acc_q          <= acc_d;
         result_r_q     <= result_r_d;
         result_valid_q <= result_valid_d;
         result_row_q   <= result_row_d;
         busy_q         <= busy_d;
      end
   end

   assign result_r     = result_r_q;
   assign result_valid = result_valid_q;
   assign result_row   = result_row_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomized bench for systolic_mac_array: two instances (32- and 16-bit accumulators) share stimulus
// and are checked against a sum-of-outer-products reference computed per job.
module tb_systolic_mac_array;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int MW = 8;
   localparam int D  = 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  num_valid = 1'b0;
   logic [15:0]           num = '0;
   logic [R-1:0][MW-1:0]  data_a = '0;
   logic [C-1:0][MW-1:0]  data_b = '0;

   logic [C-1:0][31:0]    rr32;
   logic [C-1:0][15:0]    rr16;
   logic                  v32, v16, busy32, busy16;
   logic [1:0]            row32, row16;

   int n_vec = 0;
   int n_err = 0;

   byte unsigned ba [64][R];
   byte unsigned bb [64][C];
   logic [31:0]  exp32 [R][C];
   logic [15:0]  exp16 [R][C];

   systolic_mac_array #(.MULER_WIDTH(MW), .NUM_WIDTH(16), .OUTPUT_WIDTH(32), .MULER_DELAY(D),
                        .ROW_SIZE(R), .COLUMN_SIZE(C)) dut32 (
      .clk(clk), .rst(rst), .num_valid(num_valid), .num(num), .data_a(data_a), .data_b(data_b),
      .result_r(rr32), .result_valid(v32), .result_row(row32), .busy(busy32));

   systolic_mac_array #(.MULER_WIDTH(MW), .NUM_WIDTH(16), .OUTPUT_WIDTH(16), .MULER_DELAY(D),
                        .ROW_SIZE(R), .COLUMN_SIZE(C)) dut16 (
      .clk(clk), .rst(rst), .num_valid(num_valid), .num(num), .data_a(data_a), .data_b(data_b),
      .result_r(rr16), .result_valid(v16), .result_row(row16), .busy(busy16));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint elem(input byte unsigned x);
`ifdef SIGNED_MUL_EN
      return longint'(signed'(x));
`else
      return longint'(x);
`endif
   endfunction

   task automatic build_model(input int k);
      longint s;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) begin
            s = 0;
            for (int b = 0; b < k; b++) s += elem(ba[b][i]) * elem(bb[b][j]);
            exp32[i][j] = s[31:0];
            exp16[i][j] = s[15:0];
         end
   endtask

   task automatic fill_random(input int k);
      for (int b = 0; b < k; b++) begin
         for (int i = 0; i < R; i++) ba[b][i] = 8'($urandom);
         for (int j = 0; j < C; j++) bb[b][j] = 8'($urandom);
      end
   endtask

   task automatic drive_beat(input int b);
      for (int i = 0; i < R; i++) data_a[i] = ba[b][i];
      for (int j = 0; j < C; j++) data_b[j] = bb[b][j];
   endtask

   // Caller is #1 after a rising edge; the job is accepted on the next edge.
   task automatic run_job(input int k, input bit pulse, input string tag);
      int n;
      build_model(k);
      num_valid = 1'b1;
      num       = 16'(k);
      @(posedge clk); #1;
      num_valid = 1'b0;
      num       = 16'($urandom);
      chk({tag, " busy_after_accept"}, 64'(busy32), 64'(1));
      for (int b = 0; b < k; b++) begin
         drive_beat(b);
         if (pulse && b == 1) begin
            num_valid = 1'b1;
            num       = 16'(k + 3);
         end else begin
            num_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      num_valid = 1'b0;
      data_a    = 32'($urandom);
      data_b    = 32'($urandom);
      n = 0;
      while (!v32 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'((k == 0) ? 1 : D + 1));
      for (int r = 0; r < R; r++) begin
         chk($sformatf("%s valid r%0d", tag, r), 64'({v32, v16}), 64'(2'b11));
         chk($sformatf("%s row r%0d", tag, r), 64'({row32, row16}), 64'({2'(r), 2'(r)}));
         for (int j = 0; j < C; j++) begin
            chk($sformatf("%s c32 r%0d c%0d", tag, r, j), 64'(rr32[j]), 64'(exp32[r][j]));
            chk($sformatf("%s c16 r%0d c%0d", tag, r, j), 64'(rr16[j]), 64'(exp16[r][j]));
         end
         @(posedge clk); #1;
      end
      chk({tag, " valid_after"}, 64'({v32, v16}), 64'(0));
      chk({tag, " busy_after"}, 64'({busy32, busy16}), 64'(0));
      chk({tag, " hold"}, 64'(rr32[C-1]), 64'(exp32[R-1][C-1]));
   endtask

   initial begin
      #12;
      chk("reset valid", 64'({v32, v16}), 64'(0));
      chk("reset busy", 64'({busy32, busy16}), 64'(0));
      chk("reset row", 64'({row32, row16}), 64'(0));
      chk("reset result", 64'(rr32), 64'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 4; i++) begin
            ba[b][i] = (i == 3 - b) ? 8'd1 : 8'd0;
            bb[b][i] = ba[b][i];
         end
      run_job(4, 1'b0, "identity");

      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 4; i++) begin
            ba[b][i] = 8'd1;
            bb[b][i] = 8'd1;
         end
      run_job(3, 1'b0, "ones");

      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 4; i++) begin
            ba[b][i] = 8'd255;
            bb[b][i] = 8'd255;
         end
      run_job(2, 1'b0, "wrap");

      run_job(0, 1'b0, "zero");

      fill_random(4);
      run_job(4, 1'b1, "nv_ignored");

      // Abort a job mid-accumulation.
      fill_random(5);
      num_valid = 1'b1;
      num       = 16'd5;
      @(posedge clk); #1;
      num_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         drive_beat(b);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      chk("abort valid", 64'({v32, v16}), 64'(0));
      chk("abort busy", 64'({busy32, busy16}), 64'(0));
      chk("abort result", 64'(rr32), 64'(0));
      chk("abort result16", 64'(rr16), 64'(0));
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("abort hold c%0d", c), 64'({v32, busy32}), 64'(0));
      end
      rst = 1'b1;
      @(posedge clk); #1;
      fill_random(4);
      run_job(4, 1'b0, "after_abort");

      for (int t = 0; t < 6; t++) begin
         int k;
         k = int'($urandom_range(1, 10));
         fill_random(k);
         run_job(k, 1'b0, $sformatf("rand%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
- ROW_SIZE x COLUMN_SIZE array of multiply-accumulate cells that computes a matrix product as a sum of outer products.
- A job starts with a beat count `num`. Each later cycle supplies one column of A (`data_a`) and one row of B (`data_b`), and cell (i,j) accumulates a[i]*b[j].
- When all beats are in, the result matrix is drained one row per cycle on `result_r`.
- Sits behind the matrix-multiplier operand feeder; its rows go to the result writer.

Parameters:
- MULER_WIDTH, 8: width of each operand element.
- NUM_WIDTH, 16: width of the beat-count input.
- OUTPUT_WIDTH, 32: width of each accumulator and result element.
- MULER_DELAY, 1: multiplier pipeline stages, must be >= 1.
- ROW_SIZE, 4: number of A elements per beat, which is also the number of result rows.
- COLUMN_SIZE, 4: number of B elements per beat, which is also the number of elements per result row.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- num_valid  in  1  job start strobe; sampled only in IDLE.
- num  in  NUM_WIDTH  number of operand beats (inner dimension K).
- data_a  in  ROW_SIZE x MULER_WIDTH  packed; element i = data_a[i].
- data_b  in  COLUMN_SIZE x MULER_WIDTH  packed; element j = data_b[j].
- result_r  out  COLUMN_SIZE x OUTPUT_WIDTH  current result row; element j = C[row][j].
- result_valid  out  1  result_r carries a valid row this cycle.
- result_row  out  max(1,$clog2(ROW_SIZE))  index of the row on result_r.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous) clears the following to 0 and returns to IDLE:
  - all accumulators and the multiplier pipeline;
  - beat and row counters;
  - result_r, result_valid, result_row, busy.
- Reset mid-job aborts the job with no output.
- State machine:
  - IDLE: on an edge with num_valid=1, latch num into the beat counter, clear all accumulators, and go to ACCUM. If num=0, go directly to DRAIN instead, which outputs a zero matrix.
  - ACCUM: every cycle, unconditionally sample data_a/data_b. There is no data-valid qualifier; beats must be presented on consecutive cycles starting the edge after num_valid is accepted. Decrement the counter per beat. After the last beat go to FLUSH.
  - FLUSH: stay MULER_DELAY cycles so every in-flight product is accumulated, then go to DRAIN.
  - DRAIN: over ROW_SIZE consecutive cycles drive rows 0..ROW_SIZE-1 with result_valid=1. After the last row go to IDLE.
- num_valid is ignored outside IDLE.
- Datapath:
  - Product p[i][j] = a[i]*b[j], full 2*MULER_WIDTH bits, registered through MULER_DELAY stages.
  - Each product is zero-extended to OUTPUT_WIDTH and added to acc[i][j].
  - Accumulation is modulo 2^OUTPUT_WIDTH; overflow wraps with no flag.
- Timing, MULER_DELAY=1, num=4, accept at edge 0:
  - beats sampled at edges 1–4;
  - last accumulation at edge 5;
  - row r registered at edge 6+r, so result_valid is high after edges 6..9;
  - busy low after edge 10.
  - In general, row 0 appears MULER_DELAY+1 edges after the last beat.
- Outputs are registered. result_r holds its last value while result_valid=0.

Optional Feature:
- Macro: SIGNED_MUL_EN.
- Defined: operands are treated as two's complement, and products are sign-extended to OUTPUT_WIDTH before accumulating.
- Undefined: unsigned multiply with zero-extension.

Test Plan:
- Identity: num=4, then beats a=b=e3, e2, e1, e0, where e3 = {1,0,0,0} packed with element [3]=1 → rows 0..3 are unit vectors; row r has element r=1 and all others 0, i.e. result_r = 1 << (32*r). Four consecutive valid cycles, starting 2 edges after the last beat.
- All-ones: num=3, a=b={1,1,1,1} each beat → every element is 3 in every row.
- Wrap: num=2, a=b={255,...} → each element is 2*65025 = 130050. With OUTPUT_WIDTH=16 the element wraps to 130050 mod 65536 = 64514.
- num=0 → IDLE → DRAIN directly; 4 rows of zeros with result_valid.
- Mid-job reset: assert rst low during ACCUM → all outputs 0 immediately, no result_valid. A new job afterwards gives correct results.
- num_valid pulsed during ACCUM with a different num → ignored; the original beat count and results are unchanged.
